// File: rtl/tube_pkg.sv
// Shared types and constants for the tube-emulation latch fabric.
// Holds the latch rail pair struct, its reset/both-set values, and the delay limit.
package tube_pkg;

   typedef struct packed {
      logic q;
      logic nq;
   } lat_pair_t;

   localparam lat_pair_t LAT_RESET_PAIR   = '{q: 1'b0, nq: 1'b1};
   localparam lat_pair_t LAT_BOTHSET_PAIR = '{q: 1'b1, nq: 1'b1};
   localparam lat_pair_t LAT_PRESET_PAIR  = '{q: 1'b1, nq: 1'b0};

   localparam int DELAY_MAX = 3;

endpackage

// File: rtl/dlat_bit.sv
// One tube NAND-latch bit: preset/clear priority, both-low memory, race flag.
// Ports: clk, rst_n, upd (U), gate_open, d, pc_n, ps_n, race_clr -> pair, race.
module dlat_bit
   import tube_pkg::*;
#(
   parameter bit RACE_RES = 1'b0
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      upd,
   input  logic      gate_open,
   input  logic      d,
   input  logic      pc_n,
   input  logic      ps_n,
   input  logic      race_clr,
   output lat_pair_t pair,
   output logic      race
);

   lat_pair_t pair_q, pair_d;
   logic      bl_q, bl_d;
   logic      race_q, race_d;

   always_comb begin
      pair_d = pair_q;
      bl_d   = bl_q;
      race_d = race_q;
      if (race_clr) begin
         race_d = 1'b0;
      end
      if (upd) begin
         bl_d = 1'b0;
         priority case (1'b1)
            (!pc_n && !ps_n): begin
               pair_d = LAT_BOTHSET_PAIR;
               bl_d   = 1'b1;
            end
            !pc_n: pair_d = LAT_RESET_PAIR;
            !ps_n: pair_d = LAT_PRESET_PAIR;
            // both rails released together: the tube pair races
            bl_q: begin
               pair_d = '{q: RACE_RES, nq: ~RACE_RES};
               race_d = 1'b1;
            end
            gate_open: pair_d = '{q: d, nq: ~d};
            default: pair_d = pair_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pair_q <= LAT_RESET_PAIR;
         bl_q   <= 1'b0;
         race_q <= 1'b0;
      end else begin
         pair_q <= pair_d;
         bl_q   <= bl_d;
         race_q <= race_d;
      end
   end

   assign pair = pair_q;
   assign race = race_q;

endmodule

// File: rtl/dlat_bank.sv
// WIDTH-bit tube latch bank with shared gate edge detect and U-qualified delay pipe.
// Ports: CLOCK, RESET_N, U, D, G, _PC, _PS, RACE_CLR -> Q, _Q, RACE, SETTLED.
module dlat_bank
   import tube_pkg::*;
#(
   parameter int WIDTH    = 12,
   parameter int DELAY    = 1,
   parameter int EDGE     = 0,
   parameter bit RACE_RES = 1'b0
) (
   input  logic             CLOCK,
   input  logic             RESET_N,
   input  logic             U,
   input  logic [WIDTH-1:0] D,
   input  logic             G,
   input  logic [WIDTH-1:0] _PC,
   input  logic [WIDTH-1:0] _PS,
   input  logic             RACE_CLR,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] _Q,
   output logic [WIDTH-1:0] RACE,
   output logic             SETTLED
);

   localparam int DLY = (DELAY > DELAY_MAX) ? DELAY_MAX : DELAY;

   typedef lat_pair_t [WIDTH-1:0] row_t;

   localparam row_t RST_ROW = {WIDTH{LAT_RESET_PAIR}};

   row_t state_row;
   row_t out_row;
   logic gh_q, gh_d;
   logic gate_open;

   // G history only advances on updates so edge mode survives U=0 gaps
   always_comb begin
      gh_d = U ? G : gh_q;
      gate_open = (EDGE != 0) ? (G & ~gh_q) : G;
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         gh_q <= 1'b0;
      end else begin
         gh_q <= gh_d;
      end
   end

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      dlat_bit #(
         .RACE_RES (RACE_RES)
      ) u_bit (
         .clk       (CLOCK),
         .rst_n     (RESET_N),
         .upd       (U),
         .gate_open (gate_open),
         .d         (D[b]),
         .pc_n      (_PC[b]),
         .ps_n      (_PS[b]),
         .race_clr  (RACE_CLR),
         .pair      (state_row[b]),
         .race      (RACE[b])
      );
   end

   if (DLY == 0) begin : g_nodly
      assign out_row = state_row;
      assign SETTLED = 1'b1;
   end else begin : g_dly
      row_t pipe_q [DLY];
      row_t pipe_d [DLY];
      logic settled;

      always_comb begin
         pipe_d = pipe_q;
         if (U) begin
            pipe_d[0] = state_row;
            for (int i = 1; i < DLY; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end
      end

      always_ff @(posedge CLOCK or negedge RESET_N) begin
         if (!RESET_N) begin
            for (int i = 0; i < DLY; i++) begin
               pipe_q[i] <= RST_ROW;
            end
         end else begin
            pipe_q <= pipe_d;
         end
      end

      always_comb begin
         settled = 1'b1;
         for (int i = 0; i < DLY; i++) begin
            if (pipe_q[i] != state_row) begin
               settled = 1'b0;
            end
         end
      end

      assign out_row = pipe_q[DLY-1];
      assign SETTLED = settled;
   end

   always_comb begin
      for (int b = 0; b < WIDTH; b++) begin
         Q[b]  = out_row[b].q;
         _Q[b] = out_row[b].nq;
      end
   end

endmodule

// File: tb/tb_dlat_bank.sv
// Scoreboard bench for dlat_bank: two configurations driven in parallel.
// Inst 0: W8 D2 level RR0; inst 1: W8 D1 edge RR1.
module tb_dlat_bank;

   logic       clk;
   logic       rst_n;
   logic       u;
   logic [7:0] d;
   logic       g;
   logic [7:0] pc;
   logic [7:0] ps;
   logic       clr;

   logic [7:0] q0, nq0, rc0;
   logic       st0;
   logic [7:0] q1, nq1, rc1;
   logic       st1;

   int n_chk;
   int n_fail;

   typedef struct packed {
      logic [7:0] q;
      logic [7:0] nq;
      logic [7:0] race;
      logic       st;
   } obs_t;

   obs_t exp0 [$];
   obs_t exp1 [$];

   // model: history index 0 = current latch state, k = state k updates ago
   logic [7:0] hq   [2][4];
   logic [7:0] hnq  [2][4];
   logic [7:0] mbl  [2];
   logic [7:0] mrace[2];
   logic       mgh  [2];
   int         m_dl [2];
   int         m_ed [2];
   logic       m_rr [2];

   dlat_bank #(
      .WIDTH(8), .DELAY(2), .EDGE(0), .RACE_RES(1'b0)
   ) u0 (
      .CLOCK(clk), .RESET_N(rst_n), .U(u), .D(d), .G(g),
      ._PC(pc), ._PS(ps), .RACE_CLR(clr),
      .Q(q0), ._Q(nq0), .RACE(rc0), .SETTLED(st0)
   );

   dlat_bank #(
      .WIDTH(8), .DELAY(1), .EDGE(1), .RACE_RES(1'b1)
   ) u1 (
      .CLOCK(clk), .RESET_N(rst_n), .U(u), .D(d), .G(g),
      ._PC(pc), ._PS(ps), .RACE_CLR(clr),
      .Q(q1), ._Q(nq1), .RACE(rc1), .SETTLED(st1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act,
                      input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int i);
      for (int k = 0; k < 4; k++) begin
         hq[i][k]  = 8'h00;
         hnq[i][k] = 8'hFF;
      end
      mbl[i]   = 8'h00;
      mrace[i] = 8'h00;
      mgh[i]   = 1'b0;
   endtask

   task automatic model_step(input int i, input logic r, input logic uu,
                             input logic gg, input logic cc,
                             input logic [7:0] dd, input logic [7:0] pp,
                             input logic [7:0] ss);
      logic       go;
      logic [7:0] nq_new;
      logic [7:0] nnq_new;
      if (!r) begin
         model_reset(i);
         return;
      end
      if (cc) mrace[i] = 8'h00;
      if (!uu) return;
      go = (m_ed[i] != 0) ? (gg && !mgh[i]) : gg;
      mgh[i] = gg;
      nq_new  = hq[i][0];
      nnq_new = hnq[i][0];
      for (int b = 0; b < 8; b++) begin
         if (!pp[b] && !ss[b]) begin
            nq_new[b] = 1'b1; nnq_new[b] = 1'b1;
         end else if (!pp[b]) begin
            nq_new[b] = 1'b0; nnq_new[b] = 1'b1;
         end else if (!ss[b]) begin
            nq_new[b] = 1'b1; nnq_new[b] = 1'b0;
         end else if (mbl[i][b]) begin
            nq_new[b]  = m_rr[i];
            nnq_new[b] = ~m_rr[i];
            mrace[i][b] = 1'b1;
         end else if (go) begin
            nq_new[b] = dd[b]; nnq_new[b] = ~dd[b];
         end
      end
      mbl[i] = ~pp & ~ss;
      for (int k = 3; k > 0; k--) begin
         hq[i][k]  = hq[i][k-1];
         hnq[i][k] = hnq[i][k-1];
      end
      hq[i][0]  = nq_new;
      hnq[i][0] = nnq_new;
   endtask

   function automatic obs_t model_obs(input int i);
      obs_t o;
      o.q    = hq[i][m_dl[i]];
      o.nq   = hnq[i][m_dl[i]];
      o.race = mrace[i];
      o.st   = 1'b1;
      for (int k = 1; k <= m_dl[i]; k++) begin
         if (hq[i][k] != hq[i][0] || hnq[i][k] != hnq[i][0]) o.st = 1'b0;
      end
      return o;
   endfunction

   task automatic drive(input logic r, input logic uu, input logic gg,
                        input logic cc, input logic [7:0] dd,
                        input logic [7:0] pp, input logic [7:0] ss);
      @(negedge clk);
      rst_n = r; u = uu; g = gg; clr = cc; d = dd; pc = pp; ps = ss;
      if (!r) begin
         #1;
         chk("rst_q0", q0, 8'h00);
         chk("rst_nq0", nq0, 8'hFF);
         chk("rst_q1", q1, 8'h00);
         chk("rst_st0", {7'd0, st0}, 8'h01);
      end
      for (int i = 0; i < 2; i++) model_step(i, r, uu, gg, cc, dd, pp, ss);
      exp0.push_back(model_obs(0));
      exp1.push_back(model_obs(1));
   endtask

   always @(posedge clk) begin
      obs_t e;
      #1;
      if (exp0.size() > 0) begin
         e = exp0.pop_front();
         chk("q0", q0, e.q);
         chk("nq0", nq0, e.nq);
         chk("race0", rc0, e.race);
         chk("settled0", {7'd0, st0}, {7'd0, e.st});
      end
      if (exp1.size() > 0) begin
         e = exp1.pop_front();
         chk("q1", q1, e.q);
         chk("nq1", nq1, e.nq);
         chk("race1", rc1, e.race);
         chk("settled1", {7'd0, st1}, {7'd0, e.st});
      end
   end

   initial begin
      int r;
      logic [7:0] rp, rs;
      n_chk = 0;
      n_fail = 0;
      m_dl = '{2, 1};
      m_ed = '{0, 1};
      m_rr = '{1'b0, 1'b1};
      model_reset(0);
      model_reset(1);
      rst_n = 1'b0; u = 1'b0; g = 1'b0; clr = 1'b0;
      d = 8'h00; pc = 8'hFF; ps = 8'hFF;

      drive(0, 0, 0, 0, 8'h00, 8'hFF, 8'hFF);
      drive(0, 0, 0, 0, 8'h00, 8'hFF, 8'hFF);
      // capture A5 then let it ripple through the pipe
      drive(1, 1, 1, 0, 8'hA5, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
      // hold with U low while D/G toggle
      drive(1, 1, 1, 0, 8'h3C, 8'hFF, 8'hFF);
      for (int k = 0; k < 5; k++)
         drive(1, 0, k[0], 0, 8'h55 ^ 8'(k), 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
      // per-bit clear/preset then both-low
      drive(1, 1, 0, 0, 8'h00, 8'hF0, 8'h0F);
      drive(1, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
      drive(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
      drive(1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
      // full release with gate open: race first, data next update
      drive(1, 1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
      drive(1, 1, 1, 0, 8'hFF, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'hFF, 8'hFF, 8'hFF);
      // edge mode: only the first high-G update captures
      drive(1, 1, 0, 1, 8'h00, 8'hFF, 8'hFF);
      drive(1, 1, 1, 0, 8'h11, 8'hFF, 8'hFF);
      drive(1, 1, 1, 0, 8'h22, 8'hFF, 8'hFF);
      drive(1, 1, 1, 0, 8'h33, 8'hFF, 8'hFF);
      drive(1, 1, 1, 0, 8'h33, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h33, 8'hFF, 8'hFF);
      drive(1, 1, 1, 0, 8'h44, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h44, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h44, 8'hFF, 8'hFF);
      // race on bit 3 coinciding with RACE_CLR
      drive(1, 1, 0, 0, 8'h00, 8'hF7, 8'hF7);
      drive(1, 1, 0, 1, 8'h00, 8'hFF, 8'hFF);
      drive(1, 1, 1, 0, 8'hC3, 8'hFF, 8'hFF);
      // reset mid-pipeline
      drive(0, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);
      drive(1, 1, 0, 0, 8'h00, 8'hFF, 8'hFF);

      for (int n = 0; n < 800; n++) begin
         r = $urandom_range(0, 99);
         if (r < 70) begin
            rp = 8'hFF; rs = 8'hFF;
         end else if (r < 80) begin
            rp = 8'($urandom); rs = 8'($urandom);
         end else if (r < 88) begin
            rp = 8'h00; rs = 8'($urandom) & 8'h0F;
         end else begin
            rp = 8'($urandom); rs = 8'hFF;
         end
         drive(($urandom_range(0, 99) != 0),
               ($urandom_range(0, 9) < 8),
               1'($urandom),
               ($urandom_range(0, 9) == 0),
               8'($urandom), rp, rs);
      end

      for (int k = 0; k < 10 && (exp0.size() > 0 || exp1.size() > 0); k++)
         @(posedge clk);
      #2;
      n_chk++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d/%0d expected entries left, required 0",
                  exp0.size(), exp1.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
